bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-master arbiter placed in front of the single master port of the SoC bus. Master 0 is the core LSU; master 1 is the JTAG debug module.
- Round-robin arbitration; one outstanding transaction at a time.
- Registers the winning request and holds addr/sel/we/data stable until completion, because the bus decodes the rvalid/rdata return path from the live address.

Parameters:
- TIMEOUT_CYCLES, 255: read-wait cycles before forced completion (used only with ARB_TIMEOUT_EN); legal range 1..65535.
- TIMEOUT_RDATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m0_req_i  in  1  master 0 request; held until m0_gnt_o (write) or m0_rvalid_o (read).
- m0_sel_i  in  4  byte select.
- m0_addr_i  in  32  address.
- m0_we_i  in  1  1 = write.
- m0_data_i  in  32  write data.
- m0_gnt_o  out  1  one-cycle pulse: request issued to bus.
- m0_rvalid_o  out  1  one-cycle pulse: read data valid.
- m0_data_o  out  32  read data.
- m0_err_o  out  1  one-cycle pulse with rvalid on timeout.
- m1_*  same set as m0_*, for master 1.
- s_req_o  out  1  to bus m_req_i.
- s_sel_o  out  4  to bus m_sel_i.
- s_addr_o  out  32  to bus m_addr_i.
- s_we_o  out  1  to bus m_we_i.
- s_data_o  out  32  to bus m_data_i.
- s_rvalid_i  in  1  from bus m_rvalid_o.
- s_data_i  in  32  from bus m_data_o.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all outputs 0; latched request regs 0.
  - last_owner=1, so master 0 wins the first tie.
  - Reset mid-transaction abandons it; no gnt/rvalid is emitted for it.
- States:
  - IDLE: samples m0_req_i/m1_req_i.
    - Neither requesting: stay in IDLE.
    - One requesting: it wins.
    - Both requesting: the master != last_owner wins.
    - On a win: latch the winner's sel/addr/we/data, set owner and last_owner, go to ISSUE.
  - ISSUE (1 cycle):
    - s_req_o=1; owner's gnt_o=1.
    - Write (we=1): transaction complete; next state IDLE. No rvalid is generated for writes.
    - Read with s_rvalid_i=1 in this cycle (combinational slave): owner rvalid_o=1 and data_o=s_data_i in this same cycle; next state IDLE.
    - Otherwise: next state WAIT.
  - WAIT:
    - s_req_o=0; s_addr/sel/we/data still driven from the latched regs.
    - On s_rvalid_i=1: owner rvalid_o=1, data_o=s_data_i (combinational pass-through); next state IDLE.
- Latency: request sampled in cycle N → s_req_o and gnt in N+1. Read data reaches the master in the same cycle the bus returns it.
- s_* outputs outside ISSUE/WAIT are 0.
- The non-owner's gnt/rvalid/err/data outputs are 0 at all times.
- Master protocol: deassert req or present a new request in the cycle after gnt (write) or rvalid (read). The arbiter returns to IDLE in that cycle, so it sees the updated req.
- No grant preemption. A master requesting while the other owns the bus waits. Worst-case wait is one transaction, since round-robin alternates.
- Requests arriving during ISSUE/WAIT are not sampled until IDLE.
- Addresses that decode to no slave:
  - Writes complete normally (only ISSUE is needed).
  - Reads hang in WAIT unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When counter == TIMEOUT_CYCLES-1 and s_rvalid_i=0: owner rvalid_o=1, data_o=TIMEOUT_RDATA, err_o=1; next state IDLE.
  - If s_rvalid_i=1 arrives in that same cycle, the real data wins and err_o=0.
- Undefined:
  - No counter is present; WAIT persists until s_rvalid_i.
  - m0_err_o and m1_err_o are tied to 0.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the owner encoding (OWNER_M0=0, OWNER_M1=1);
  - the default TIMEOUT_RDATA constant.
- One natural sub-module, bus_arb_rr_pick: combinational two-way round-robin picker (inputs req[1:0], last_owner; outputs valid, winner).
- The FSM, latches and counter stay in bus_arbiter.

Test Plan:
- m0 read at 0x2004; slave returns rvalid 2 cycles after s_req_o with 0x12345678.
  - Required: gnt at N+1; s_addr_o=0x2004 held through WAIT; m0_rvalid_o with 0x12345678 at N+3; m1 outputs remain 0.
- m0 write at 0x5000, data 0xA5, sel 4'b0001.
  - Required: s_req_o/s_we_o/m0_gnt_o high exactly one cycle at N+1; no rvalid; IDLE at N+2.
- m0 and m1 both request reads continuously for 4 transactions, first tie after reset.
  - Required: grant order m0, m1, m0, m1.
- Read with combinational slave (rvalid in the issue cycle).
  - Required: gnt and rvalid in the same cycle; the next request is issued 2 cycles later.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4; m1 reads unmapped 0x80000000.
  - Required: m1_rvalid_o=1, m1_data_o=0xDEADBEEF, m1_err_o=1 on the 4th WAIT cycle; arbiter back in IDLE.
- rst_i asserted mid-WAIT, then slave rvalid pulses.
  - Required: outputs 0 immediately (asynchronously); rvalid ignored; first grant after release goes to m0 on a tie.

Source files
------------

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the two-master bus arbiter:
//                FSM state encoding, owner encoding and the default read
//                data returned when a read is forced to complete.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/bus_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_rr_pick
//  Description : Combinational two-way round-robin picker. A lone requester
//                wins outright; on a tie the master that did not own the bus
//                last time wins.
//  Ports       : req[1:0]    request vector (bit 0 = master 0)
//                last_owner  owner of the previous transaction
//                valid       at least one request present
//                winner      selected master (OWNER_M0 / OWNER_M1)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arb_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = OWNER_M0;
        case (req)
            2'b01:   winner = OWNER_M0;
            2'b10:   winner = OWNER_M1;
            2'b11:   winner = ~last_owner;
            default: winner = OWNER_M0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master round-robin arbiter in front of the single SoC
//                bus master port (master 0 = core LSU, master 1 = JTAG debug).
//                One transaction outstanding at a time. The winning request is
//                registered and held on s_* until completion, because the bus
//                decodes its read return path from the live address.
//  Config      : `define ARB_TIMEOUT_EN to force-complete reads that wait
//                TIMEOUT_CYCLES cycles, returning TIMEOUT_RDATA with err set.
//                Without it reads wait for s_rvalid_i and err outputs are 0.
//  Ports       : clk_i, rst_i (async, active high)
//                m0_* / m1_*  master request in, gnt/rvalid/data/err out
//                s_*          bus master port (req/sel/addr/we/data out,
//                             rvalid/data in)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // master 0
    input  logic        m0_req_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,
    output logic        m0_err_o,
    // master 1
    input  logic        m1_req_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,
    output logic        m1_err_o,
    // bus side
    output logic        s_req_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [31:0] s_data_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_data_i
);

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
            $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner;
    logic        r_last_owner;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_data;

    logic        w_pick_valid;
    logic        w_pick_winner;
    logic        w_timeout;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_active;

    bus_arb_rr_pick u_rr_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_owner (r_last_owner),
        .valid      (w_pick_valid),
        .winner     (w_pick_winner)
    );

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    // Cleared while in ISSUE so it starts at zero on the first WAIT cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Real read data arriving in the expiry cycle takes precedence.
    assign w_timeout = (r_state == WAIT) && !s_rvalid_i &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture: only sampled in IDLE, so requests arriving while the
    // bus is busy wait for the next arbitration round.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= OWNER_M0;
            r_last_owner <= OWNER_M1;
            r_sel        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_data       <= '0;
        end else if (r_state == IDLE && w_pick_valid) begin
            r_owner      <= w_pick_winner;
            r_last_owner <= w_pick_winner;
            if (w_pick_winner == OWNER_M1) begin
                r_sel  <= m1_sel_i;
                r_addr <= m1_addr_i;
                r_we   <= m1_we_i;
                r_data <= m1_data_i;
            end else begin
                r_sel  <= m0_sel_i;
                r_addr <= m0_addr_i;
                r_we   <= m0_we_i;
                r_data <= m0_data_i;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_gnt        = 1'b0;
        w_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_gnt = 1'b1;
                if (r_we) begin
                    w_next_state = IDLE;
                end else if (s_rvalid_i) begin
                    // combinational slave answered in the issue cycle
                    w_rvalid     = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (s_rvalid_i || w_timeout) begin
                    w_rvalid     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_rdata  = w_timeout ? TIMEOUT_RDATA : s_data_i;
    assign w_active = (r_state != IDLE);

    assign s_req_o  = (r_state == ISSUE);
    assign s_sel_o  = w_active ? r_sel  : '0;
    assign s_addr_o = w_active ? r_addr : '0;
    assign s_we_o   = w_active ? r_we   : 1'b0;
    assign s_data_o = w_active ? r_data : '0;

    assign m0_gnt_o    = w_gnt     && (r_owner == OWNER_M0);
    assign m0_rvalid_o = w_rvalid  && (r_owner == OWNER_M0);
    assign m0_err_o    = w_timeout && (r_owner == OWNER_M0);
    assign m0_data_o   = m0_rvalid_o ? w_rdata : '0;

    assign m1_gnt_o    = w_gnt     && (r_owner == OWNER_M1);
    assign m1_rvalid_o = w_rvalid  && (r_owner == OWNER_M1);
    assign m1_err_o    = w_timeout && (r_owner == OWNER_M1);
    assign m1_data_o   = m1_rvalid_o ? w_rdata : '0;

endmodule
`default_nettype wire
